// File: rtl/button_bcd_counter_if.sv
// Signal bundle between the button/control side and the two-digit BCD counter.
// The counter takes the slave modport; whoever drives the button and controls takes the master modport.
interface button_bcd_counter_if;
    logic       button;
    logic       enable;
    logic       hold;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic       btn_level;
    logic       press_pulse;
    logic       wrap;

    modport slave (
        input  button,
        input  enable,
        input  hold,
        output bcd_ones,
        output bcd_tens,
        output btn_level,
        output press_pulse,
        output wrap
    );

    modport master (
        output button,
        output enable,
        output hold,
        input  bcd_ones,
        input  bcd_tens,
        input  btn_level,
        input  press_pulse,
        input  wrap
    );
endinterface

// File: rtl/button_bcd_counter.sv
// Debounced active-low push-button driving a 00-99 BCD counter with enable/hold
// controls and a rollover pulse.
module button_bcd_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_bcd_counter_if.slave  bus
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    logic             sync_meta;
    logic             sync_btn;

    logic             btn_level;
    logic             press_pulse;
    logic             wrap;
    logic [3:0]       ones;
    logic [3:0]       tens;
    logic [3:0]       ones_inc;
    logic [3:0]       tens_inc;
    logic             roll;

    // Synchronizer idles at 1 (released) so reset never fakes a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_btn  <= 1'b1;
        end else begin
            sync_meta <= bus.button;
            sync_btn  <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RELEASED;
            cnt         <= '0;
            btn_level   <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_level   <= (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
            press_pulse <= accept;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            RELEASED: begin
                if (!sync_btn) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_btn) begin
                    state_nxt = RELEASED;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PRESSED;
                    accept    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (sync_btn) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_btn) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = RELEASED;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ones_inc = ones + 4'd1;
        tens_inc = tens;
        roll     = 1'b0;
        if (ones == 4'd9) begin
            ones_inc = 4'd0;
            if (tens == 4'd9) begin
                tens_inc = 4'd0;
                roll     = 1'b1;
            end else begin
                tens_inc = tens + 4'd1;
            end
        end
    end

    // A pulse arriving while disabled or held is simply dropped, never queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= '0;
            tens <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!bus.enable) begin
                ones <= '0;
                tens <= '0;
            end else if (!bus.hold && press_pulse) begin
                ones <= ones_inc;
                tens <= tens_inc;
                wrap <= roll;
            end
        end
    end

    assign bus.bcd_ones    = ones;
    assign bus.bcd_tens    = tens;
    assign bus.btn_level   = btn_level;
    assign bus.press_pulse = press_pulse;
    assign bus.wrap        = wrap;

    a_digits_bcd: assert property (@(posedge clk) disable iff (!rst_n) (ones <= 4'd9) && (tens <= 4'd9));
    a_pulse_single: assert property (@(posedge clk) disable iff (!rst_n) press_pulse |=> !press_pulse);
    a_wrap_single: assert property (@(posedge clk) disable iff (!rst_n) wrap |=> !wrap);

endmodule

// File: tb/tb_button_bcd_counter.sv
// Randomized and directed checks of button_bcd_counter against a run-length /
// integer-count reference model.
module tb_button_bcd_counter;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    button_bcd_counter_if bus ();

    button_bcd_counter #(.DEBOUNCE_CYCLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_pulse = 0;
    int n_wrap = 0;

    // Reference: raw samples reach the debouncer two edges late; the accepted level
    // flips once N+1 consecutive samples disagree with it; count is a plain integer.
    bit dq[$];
    int m_run;
    bit m_level;
    bit m_pulse;
    bit m_wrap;
    int m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        dq      = '{1'b1, 1'b1};
        m_run   = 0;
        m_level = 1'b0;
        m_pulse = 1'b0;
        m_wrap  = 1'b0;
        m_count = 0;
    endfunction

    function automatic void model_step();
        bit s;
        bit pressed;
        if (!bus.enable) begin
            m_count = 0;
            m_wrap  = 1'b0;
        end else if (!bus.hold && m_pulse) begin
            m_count = (m_count + 1) % 100;
            m_wrap  = (m_count == 0);
        end else begin
            m_wrap = 1'b0;
        end
        s = dq.pop_front();
        dq.push_back(bus.button);
        pressed = !s;
        m_pulse = 1'b0;
        if (pressed != m_level) m_run++;
        else m_run = 0;
        if (m_run == int'(N) + 1) begin
            m_level = pressed;
            m_run   = 0;
            m_pulse = pressed;
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".ones"},  32'(bus.bcd_ones),    32'(m_count % 10));
        check({tag, ".tens"},  32'(bus.bcd_tens),    32'(m_count / 10));
        check({tag, ".level"}, 32'(bus.btn_level),   32'(m_level));
        check({tag, ".pulse"}, 32'(bus.press_pulse), 32'(m_pulse));
        check({tag, ".wrap"},  32'(bus.wrap),        32'(m_wrap));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all(tag);
        if (bus.press_pulse === 1'b1) n_pulse++;
        if (bus.wrap === 1'b1) begin
            n_wrap++;
            check("wrap.digits", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h00);
        end
    endtask

    task automatic press();
        bus.button = 1'b0;
        repeat (N + 4) step("press");
        bus.button = 1'b1;
        repeat (N + 4) step("release");
    endtask

    task automatic mid_reset(input int hold_cycles);
        @(posedge clk);
        if (rst_n) model_step();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("rst_async");
        @(negedge clk);
        repeat (hold_cycles) step("rst_hold");
        rst_n = 1'b1;
    endtask

    int first;
    int p0;
    int w0;
    logic [7:0] dig8;

    initial begin
        bus.button = 1'b1;
        bus.enable = 1'b1;
        bus.hold   = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        check("reset.digits", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h00);
        rst_n = 1'b1;
        repeat (3) step("idle");

        // Clean press: pulse after E(N+3), digits move one edge later.
        bus.button = 1'b0;
        first = 0;
        p0    = n_pulse;
        dig8  = '0;
        for (int k = 1; k <= 20; k++) begin
            step("clean");
            if (bus.press_pulse === 1'b1 && first == 0) first = k;
            if (k == int'(N) + 4) dig8 = {bus.bcd_tens, bus.bcd_ones};
        end
        check("clean.latency", 32'(first), 32'(N + 3));
        check("clean.pulses", 32'(n_pulse - p0), 32'd1);
        check("clean.digits", 32'(dig8), 32'h01);
        check("clean.level", 32'(bus.btn_level), 32'd1);
        bus.button = 1'b1;
        repeat (10) step("clean_rel");

        // Bounce every two cycles never survives the stability window.
        p0 = n_pulse;
        for (int i = 0; i < 8; i++) begin
            bus.button = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) step("bounce");
        end
        bus.button = 1'b1;
        repeat (10) step("bounce_idle");
        check("bounce.pulses", 32'(n_pulse - p0), 32'd0);
        check("bounce.digits", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h01);

        bus.enable = 1'b0;
        step("clear");
        bus.enable = 1'b1;
        check("clear.digits", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h00);

        // Rollover through 100 presses.
        p0 = n_pulse;
        w0 = n_wrap;
        for (int p = 1; p <= 100; p++) begin
            press();
            if (p == 10) check("roll.p10", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h10);
            if (p == 99) begin
                check("roll.p99", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h99);
                check("roll.nowrap_yet", 32'(n_wrap - w0), 32'd0);
            end
        end
        check("roll.p100", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h00);
        check("roll.wraps", 32'(n_wrap - w0), 32'd1);
        check("roll.pulses", 32'(n_pulse - p0), 32'd100);

        // Controls.
        repeat (5) press();
        check("ctl.start", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h05);
        bus.hold = 1'b1;
        press();
        check("ctl.hold", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h05);
        bus.enable = 1'b0;
        step("ctl_dis");
        check("ctl.disable", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h00);
        bus.enable = 1'b1;
        bus.hold   = 1'b0;
        press();
        check("ctl.resume", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h01);

        // Reset while in PRESS_WAIT at 37, with the button still held through release.
        repeat (36) press();
        check("rst.pre37", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h37);
        bus.button = 1'b0;
        repeat (4) step("rst_wait");
        mid_reset(2);
        check("rst.digits", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h00);
        check("rst.outs", 32'({bus.btn_level, bus.press_pulse, bus.wrap}), 32'd0);
        p0    = n_pulse;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step("rst_fresh");
            if (bus.press_pulse === 1'b1 && first == 0) first = k;
        end
        check("rst.fresh_latency", 32'(first), 32'(N + 3));
        check("rst.fresh_pulses", 32'(n_pulse - p0), 32'd1);
        bus.button = 1'b1;
        repeat (10) step("rst_rel");

        // Random segments of button level, controls and occasional resets.
        for (int seg = 0; seg < 250; seg++) begin
            bus.button = 1'($urandom_range(0, 1));
            bus.enable = ($urandom_range(0, 15) != 0);
            bus.hold   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) begin
                mid_reset(int'($urandom_range(0, 2)));
            end else begin
                repeat ($urandom_range(1, 12)) step("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the end of stimulus");
        $fatal(1);
    end

endmodule
